// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage in front of the instruction decoder.
//
// Owns the PC and issues word-aligned requests to instruction memory. It keeps at most two
// words in flight or buffered, because returned words land in a 2-entry in-order FIFO. Decode
// sees {id_instr, id_pc} through a valid/ready handshake. A redirect (PCSel from control)
// reloads the PC, empties the FIFO and arms a kill counter that drops the responses still in
// flight.
//
// Ports:
//   clk, rst_n                  rising-edge clock, synchronous active-low reset
//   imem_req_valid/ready/addr   request channel to instruction memory (addr[1:0] == 2'b00)
//   imem_rsp_valid/data         in-order response channel from instruction memory
//   redirect, redirect_pc       taken branch/jump and its target (target[1:0] ignored)
//   id_valid/ready/instr/pc     head-of-FIFO instruction presented to decode
module instr_fetch #(
  parameter int unsigned    n        = 32,
  parameter logic [n-1:0]   RESET_PC = '0,
  parameter logic [n-1:0]   NOP      = n'(32'h0000_0013)
) (
  input  logic         clk,
  input  logic         rst_n,

  output logic         imem_req_valid,
  input  logic         imem_req_ready,
  output logic [n-1:0] imem_req_addr,
  input  logic         imem_rsp_valid,
  input  logic [n-1:0] imem_rsp_data,

  input  logic         redirect,
  input  logic [n-1:0] redirect_pc,

  output logic         id_valid,
  input  logic         id_ready,
  output logic [n-1:0] id_instr,
  output logic [n-1:0] id_pc
);

  localparam logic StBoot = 1'b0;
  localparam logic StRun  = 1'b1;

  // Architectural state.
  logic         state_q, state_d;
  logic [n-1:0] pc_q, pc_d;
  logic [1:0]   outst_q, outst_d;   // requests accepted, response not yet seen
  logic [1:0]   kill_q, kill_d;     // in-flight responses still to be dropped

  // Output FIFO (instruction + its PC).
  logic [n-1:0] fifo_instr_q [2];
  logic [n-1:0] fifo_pc_q    [2];
  logic [1:0]   count_q, count_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic         rd_ptr_q, rd_ptr_d;

  // Address queue: PC of every accepted request, consumed in order by responses.
  logic [n-1:0] aq_q [2];
  logic         aq_wr_q, aq_wr_d;
  logic         aq_rd_q, aq_rd_d;

  // Handshake decodes.
  logic         req_fire;
  logic         rsp_drop;
  logic         push;
  logic         pop;
  logic [2:0]   credit_used;
  logic [n-1:0] redirect_tgt;
  logic         unused_redirect_lsb;

  assign redirect_tgt        = {redirect_pc[n-1:2], 2'b00};
  assign unused_redirect_lsb = ^redirect_pc[1:0];

  // ---------------------------------------------------------------------------------------------
  // Request side
  // ---------------------------------------------------------------------------------------------
  // Buffered words plus words in flight never exceed the FIFO depth, so a response always has
  // a slot waiting for it and the memory never needs back-pressure on its response channel.
  assign credit_used    = {1'b0, count_q} + {1'b0, outst_q};
  assign imem_req_valid = (state_q == StRun) && (credit_used < 3'd2);
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;

  // ---------------------------------------------------------------------------------------------
  // Response / decode side
  // ---------------------------------------------------------------------------------------------
  assign rsp_drop = imem_rsp_valid & (kill_q != 2'd0);
  // A response arriving in the redirect cycle belongs to the wrong path: it is neither pushed
  // nor counted in the new kill value.
  assign push     = imem_rsp_valid & (kill_q == 2'd0) & ~redirect;

  assign id_valid = (count_q != 2'd0);
  assign pop      = id_valid & id_ready;
  assign id_instr = id_valid ? fifo_instr_q[rd_ptr_q] : NOP;
  assign id_pc    = id_valid ? fifo_pc_q[rd_ptr_q]    : '0;

  // ---------------------------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    if (state_q == StBoot) begin
      state_d = StRun;
    end
  end

  always_comb begin
    pc_d = pc_q;
    if (redirect) begin
      pc_d = redirect_tgt;
    end else if (req_fire) begin
      pc_d = pc_q + n'(4);
    end
  end

  always_comb begin
    outst_d = outst_q;
    if (req_fire && !imem_rsp_valid) begin
      outst_d = outst_q + 2'd1;
    end else if (!req_fire && imem_rsp_valid) begin
      outst_d = outst_q - 2'd1;
    end
  end

  // On redirect everything still in flight afterwards (including a request accepted in this
  // very cycle) is stale and must be dropped.
  always_comb begin
    kill_d = kill_q;
    if (redirect) begin
      kill_d = outst_d;
    end else if (rsp_drop) begin
      kill_d = kill_q - 2'd1;
    end
  end

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (redirect) begin
      // A same-cycle pop still completes (it is the branch itself); the rest is flushed.
      count_d  = 2'd0;
      wr_ptr_d = 1'b0;
      rd_ptr_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = ~rd_ptr_q;
      end
      if (push && !pop) begin
        count_d = count_q + 2'd1;
      end else if (!push && pop) begin
        count_d = count_q - 2'd1;
      end
    end
  end

  // The address queue is not flushed on redirect: killed responses still pop their entry,
  // which keeps it aligned with the memory's in-order response stream.
  always_comb begin
    aq_wr_d = aq_wr_q;
    aq_rd_d = aq_rd_q;
    if (req_fire) begin
      aq_wr_d = ~aq_wr_q;
    end
    if (imem_rsp_valid) begin
      aq_rd_d = ~aq_rd_q;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StBoot;
      pc_q     <= RESET_PC;
      outst_q  <= 2'd0;
      kill_q   <= 2'd0;
      count_q  <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      aq_wr_q  <= 1'b0;
      aq_rd_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      outst_q  <= outst_d;
      kill_q   <= kill_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      aq_wr_q  <= aq_wr_d;
      aq_rd_q  <= aq_rd_d;
    end
  end

  // Payload storage needs no reset; validity is tracked by count_q and the queue pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr_q[wr_ptr_q] <= imem_rsp_data;
      fifo_pc_q[wr_ptr_q]    <= aq_q[aq_rd_q];
    end
    if (req_fire) begin
      aq_q[aq_wr_q] <= pc_q;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Assertions
  // ---------------------------------------------------------------------------------------------
  // The memory may only answer requests it has accepted.
  a_rsp_has_req: assert property (@(posedge clk) disable iff (!rst_n)
    imem_rsp_valid |-> (outst_q != 2'd0));

  // Credit rule: buffered plus in-flight never exceeds the FIFO depth.
  a_credit: assert property (@(posedge clk) disable iff (!rst_n)
    credit_used <= 3'd2);

  // Every pending kill refers to an in-flight response.
  a_kill_bound: assert property (@(posedge clk) disable iff (!rst_n)
    kill_q <= outst_q);

  // Fetch addresses stay word aligned.
  a_addr_align: assert property (@(posedge clk) disable iff (!rst_n)
    imem_req_valid |-> (imem_req_addr[1:0] == 2'b00));

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomised stream with
// redirects. A driver pushes expected PCs into a scoreboard queue; a monitor pops and compares
// on every decode handshake. A small memory model answers requests in order.
module tb_instr_fetch;

  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam logic [31:0] Nop     = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  always #5 clk = ~clk;

  instr_fetch #(
    .n       (32),
    .RESET_PC(ResetPc),
    .NOP     (Nop)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .id_valid      (id_valid),
    .id_ready      (id_ready),
    .id_instr      (id_instr),
    .id_pc         (id_pc)
  );

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    return addr ^ 32'h5A00_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // -----------------------------------------------------------------------------------------
  // Memory model
  // -----------------------------------------------------------------------------------------
  typedef struct {
    logic [31:0] data;
    int          due;
  } rsp_t;

  rsp_t        pend[$];
  logic [31:0] acc_log[$];
  int          cyc       = 0;
  int          last_due  = 0;
  int unsigned lat_min   = 1;
  int unsigned lat_max   = 1;
  int unsigned rdy_pct   = 100;
  int          max_pend  = 0;
  int          align_err = 0;
  int          hold_err  = 0;

  initial begin
    logic        hold_pending;
    logic [31:0] hold_addr;
    int          due;
    hold_pending   = 1'b0;
    hold_addr      = '0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'hDEAD_BEEF;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend.delete();
        last_due     = 0;
        hold_pending = 1'b0;
      end else begin
        if (imem_rsp_valid) void'(pend.pop_front());
        if (hold_pending && (!imem_req_valid || imem_req_addr !== hold_addr)) hold_err++;
        hold_pending = imem_req_valid && !imem_req_ready && !redirect;
        hold_addr    = imem_req_addr;
        if (imem_req_valid && imem_req_ready) begin
          if (imem_req_addr[1:0] != 2'b00) align_err++;
          acc_log.push_back(imem_req_addr);
          due = cyc + int'($urandom_range(lat_max, lat_min));
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          pend.push_back('{mem_word(imem_req_addr), due});
          if (pend.size() > max_pend) max_pend = pend.size();
        end
      end
      @(posedge clk);
      #1;
      cyc++;
      imem_req_ready = ($urandom_range(99, 0) < rdy_pct) ? 1'b1 : 1'b0;
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = pend[0].data;
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'hDEAD_BEEF;
      end
    end
  end

  // -----------------------------------------------------------------------------------------
  // Scoreboard monitor
  // -----------------------------------------------------------------------------------------
  logic [31:0] exp_q[$];
  int          hs_cnt = 0;

  always @(negedge clk) begin
    logic [31:0] e;
    if (rst_n === 1'b1 && id_valid === 1'b1 && id_ready === 1'b1) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_instr: got pc %h, none expected", id_pc);
      end else begin
        e = exp_q.pop_front();
        chk("id_pc", id_pc, e);
        chk("id_instr", id_instr, mem_word(e));
      end
    end
  end

  // -----------------------------------------------------------------------------------------
  // Driver helpers
  // -----------------------------------------------------------------------------------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns in cycle 0 (BOOT) after reset release.
  task automatic do_reset();
    rst_n    = 1'b0;
    redirect = 1'b0;
    id_ready = 1'b0;
    tick();
    tick();
    exp_q.delete();
    acc_log.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_hs(input string name, input int k, input int budget);
    int start;
    int n;
    start = hs_cnt;
    n     = 0;
    while (hs_cnt - start < k && n < budget) begin
      tick();
      n++;
    end
    id_ready = 1'b0;
    if (hs_cnt - start < k) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got %0d handshakes expected %0d", name, hs_cnt - start, k);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  // -----------------------------------------------------------------------------------------
  // Stimulus
  // -----------------------------------------------------------------------------------------
  initial begin
    logic [31:0] exp_tail;
    logic [31:0] tgt;
    logic        was_redir;
    int          start;
    int          n;

    redirect_pc = '0;
    rst_n       = 1'b0;
    redirect    = 1'b0;
    id_ready    = 1'b0;
    tick();
    tick();
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_req_addr", imem_req_addr, ResetPc);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_instr", id_instr, Nop);
    chk("rst_id_pc", id_pc, 32'd0);

    // Basic stream, 1-cycle memory, decode always ready.
    do_reset();
    id_ready = 1'b1;
    chk("boot_req_valid", 32'(imem_req_valid), 32'd0);
    chk("boot_id_instr", id_instr, Nop);
    for (int i = 0; i < 8; i++) exp_q.push_back(32'(i * 4));
    tick();
    chk("c1_req_valid", 32'(imem_req_valid), 32'd1);
    chk("c1_req_addr", imem_req_addr, 32'h0);
    tick();
    chk("c2_id_valid", 32'(id_valid), 32'd0);
    chk("c2_id_instr", id_instr, Nop);
    tick();
    chk("c3_id_valid", 32'(id_valid), 32'd1);
    chk("c3_id_pc", id_pc, 32'h0);
    wait_hs("stream", 8, 100);

    // Decode stall with a full FIFO.
    do_reset();
    repeat (12) tick();
    chk("stall_req_count", 32'(acc_log.size()), 32'd2);
    if (acc_log.size() >= 2) begin
      chk("stall_req0", acc_log[0], 32'h0);
      chk("stall_req1", acc_log[1], 32'h4);
    end
    chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
    chk("stall_id_valid", 32'(id_valid), 32'd1);
    chk("stall_id_pc", id_pc, 32'h0);
    exp_q.push_back(32'h0);
    exp_q.push_back(32'h4);
    exp_q.push_back(32'h8);
    id_ready = 1'b1;
    wait_hs("stall_release", 3, 50);

    // Redirect with two requests in flight.
    lat_min = 4;
    lat_max = 4;
    do_reset();
    tick();
    tick();
    tick();
    chk("kill_inflight", 32'(pend.size()), 32'd2);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0103;
    tick();
    redirect = 1'b0;
    chk("kill_req_addr", imem_req_addr, 32'h0000_0100);
    chk("kill_req_valid", 32'(imem_req_valid), 32'd0);
    exp_q.push_back(32'h100);
    exp_q.push_back(32'h104);
    id_ready = 1'b1;
    wait_hs("kill", 2, 60);
    if (acc_log.size() >= 3) chk("kill_first_new_req", acc_log[2], 32'h100);
    else chk("kill_req_count", 32'(acc_log.size()), 32'd3);

    // Redirect coinciding with a response and a decode handshake.
    lat_min = 1;
    lat_max = 1;
    do_reset();
    tick();
    tick();
    tick();
    chk("same_pre_id_valid", 32'(id_valid), 32'd1);
    exp_q.push_back(32'h0);
    id_ready    = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    id_ready = 1'b0;
    chk("same_id_valid", 32'(id_valid), 32'd0);
    chk("same_req_addr", imem_req_addr, 32'h200);
    chk("same_req_valid", 32'(imem_req_valid), 32'd1);
    chk("same_consumed", 32'(exp_q.size()), 32'd0);
    exp_q.push_back(32'h200);
    exp_q.push_back(32'h204);
    id_ready = 1'b1;
    wait_hs("same", 2, 60);

    // Random latency/ready with occasional redirects.
    lat_min = 1;
    lat_max = 5;
    rdy_pct = 70;
    do_reset();
    exp_tail = ResetPc;
    tgt      = '0;
    start    = hs_cnt;
    n        = 0;
    while (hs_cnt - start < 1000 && n < 30000) begin
      while (exp_q.size() < 4) begin
        exp_q.push_back(exp_tail);
        exp_tail = exp_tail + 32'd4;
      end
      id_ready = ($urandom_range(99, 0) < 70) ? 1'b1 : 1'b0;
      if ($urandom_range(99, 0) < 3) begin
        redirect    = 1'b1;
        redirect_pc = $urandom;
        tgt         = redirect_pc & 32'hFFFF_FFFC;
      end else begin
        redirect = 1'b0;
      end
      was_redir = redirect;
      tick();
      n++;
      if (was_redir) begin
        exp_q.delete();
        exp_tail = tgt;
      end
    end
    redirect = 1'b0;
    id_ready = 1'b0;
    if (hs_cnt - start < 1000) begin
      checks++;
      errors++;
      $display("FAIL random_timeout: got %0d handshakes expected 1000", hs_cnt - start);
    end
    chk("max_outstanding_le2", 32'(max_pend <= 2), 32'd1);
    chk("addr_align_errors", 32'(align_err), 32'd0);
    chk("req_hold_errors", 32'(hold_err), 32'd0);

    // Reset in the middle of a stalled, full stream.
    lat_min = 1;
    lat_max = 1;
    rdy_pct = 100;
    do_reset();
    repeat (10) tick();
    chk("mid_pre_id_valid", 32'(id_valid), 32'd1);
    rst_n = 1'b0;
    tick();
    chk("mid_id_valid", 32'(id_valid), 32'd0);
    chk("mid_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    exp_q.delete();
    acc_log.delete();
    rst_n = 1'b1;
    tick();
    chk("mid_post_req_valid", 32'(imem_req_valid), 32'd1);
    chk("mid_post_req_addr", imem_req_addr, ResetPc);
    exp_q.push_back(ResetPc);
    id_ready = 1'b1;
    wait_hs("mid_post", 1, 20);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
